sram_controller: RTL and testbench

- Sequences the 16-bit external data SRAM on behalf of the MEM stage's 32-bit load/store requests.
- Splits each word access into a low-halfword phase and a high-halfword phase, each with programmable wait states.
- Drives `ready` low while an access is in flight; the top level derives the pipeline freeze as `(rd_en | wr_en) & ~ready`.
- Sits between the exec/mem pipeline register outputs (ALU result as address, Rm value as store data) and the SRAM pins.

---
 rtl/sram_pkg.sv | 17 +
 rtl/sram_wait_counter.sv | 24 ++
 rtl/sram_controller.sv | 105 ++++++++++
 tb/tb_sram_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared encodings for the 16-bit SRAM controller: FSM states, op codes and bus constants.
package sram_pkg;

  localparam int          SRAM_DQ_W         = 16;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOW  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait-state counter: runs 0..ACCESS_CYCLES-1 and flags the final cycle of a phase.
module sram_wait_counter #(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic last
);

  localparam int CNT_W = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;

  logic [CNT_W-1:0] count;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       count <= '0;
    else if (clear) count <= '0;
    else            count <= count + 1'b1;
  end

  assign last = (count == CNT_W'(ACCESS_CYCLES - 1));

endmodule

// File: rtl/sram_controller.sv
// Sequences a 32-bit load/store into two 16-bit SRAM halfword phases with programmable wait states.
module sram_controller
  import sram_pkg::*;
#(
  parameter int          ADDR_W        = 18,
  parameter int          ACCESS_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [31:0]          address,
  input  logic [31:0]          write_data,
  output logic [31:0]          read_data,
  output logic                 ready,
  output logic [ADDR_W-1:0]    sram_addr,
  output logic [SRAM_DQ_W-1:0] sram_dq_out,
  input  logic [SRAM_DQ_W-1:0] sram_dq_in,
  output logic                 sram_dq_oe,
  output logic                 sram_we_n,
  output logic                 sram_oe_n,
  output logic                 sram_ce_n
);

  logic [1:0]        state, state_nxt;
  op_e               op_q;
  logic [ADDR_W-2:0] word_addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       offset;
  logic              active, is_wr, last, req;
  logic              unused_offset_bits;

  assign req    = rd_en | wr_en;
  assign offset = address - BASE_ADDR;
  assign active = (state == ST_LOW) || (state == ST_HIGH);
  assign is_wr  = (op_q == OP_WR);

  // Only the word-aligned slice reaches the pins; the rest wraps away silently.
  assign unused_offset_bits = ^{offset[31:ADDR_W+1], offset[1:0]};

  sram_wait_counter #(
    .ACCESS_CYCLES(ACCESS_CYCLES)
  ) u_wait_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(!active || last),
    .last (last)
  );

  // NOTE: next-state logic assigns a default first, so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (req)  state_nxt = ST_LOW;
      ST_LOW:  if (last) state_nxt = ST_HIGH;
      ST_HIGH: if (last) state_nxt = ST_DONE;
      default:           state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      op_q        <= OP_RD;
      word_addr_q <= '0;
      wdata_q     <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req) begin
        op_q        <= wr_en ? OP_WR : OP_RD;
        word_addr_q <= offset[ADDR_W:2];
        wdata_q     <= write_data;
      end
    end
  end

  // Each halfword is captured on the final wait-state cycle of its phase.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_data <= '0;
    end else if (active && last && !is_wr) begin
      if (state == ST_LOW) read_data[15:0]  <= sram_dq_in;
      else                 read_data[31:16] <= sram_dq_in;
    end
  end

  always_comb begin
    ready = 1'b0;
    case (state)
      ST_IDLE: ready = !req;
      ST_DONE: ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // The strobe rises on the last cycle of a phase so data is held before the address moves.
  assign sram_ce_n   = !active;
  assign sram_we_n   = !(active && is_wr && !last);
  assign sram_oe_n   = !(active && !is_wr);
  assign sram_dq_oe  = active && is_wr;
  assign sram_addr   = {word_addr_q, (state == ST_HIGH)};
  assign sram_dq_out = (state == ST_HIGH) ? wdata_q[31:16] : wdata_q[15:0];

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: table-driven accesses against a behavioural SRAM plus corner sequences.
module tb_sram_controller;

  localparam int ADDR_W = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data, read_data;
  logic        ready;
  logic [ADDR_W-1:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n;

  logic        rd_en3, wr_en3;
  logic [31:0] address3, write_data3, read_data3;
  logic        ready3;
  logic [ADDR_W-1:0] sram_addr3;
  logic [15:0] sram_dq_out3;
  logic        sram_dq_oe3, sram_we_n3, sram_oe_n3, sram_ce_n3;

  logic [15:0] mem [0:(1<<ADDR_W)-1];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_controller #(.ADDR_W(ADDR_W), .ACCESS_CYCLES(2), .BASE_ADDR(32'd1024)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
    .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n),
    .sram_ce_n(sram_ce_n)
  );

  sram_controller #(.ADDR_W(ADDR_W), .ACCESS_CYCLES(3), .BASE_ADDR(32'd1024)) u_dut3 (
    .clk(clk), .rst(rst), .rd_en(rd_en3), .wr_en(wr_en3), .address(address3),
    .write_data(write_data3), .read_data(read_data3), .ready(ready3),
    .sram_addr(sram_addr3), .sram_dq_out(sram_dq_out3), .sram_dq_in(16'h0000),
    .sram_dq_oe(sram_dq_oe3), .sram_we_n(sram_we_n3), .sram_oe_n(sram_oe_n3),
    .sram_ce_n(sram_ce_n3)
  );

  // Behavioural asynchronous SRAM: write sampled at the clock edge while strobed, read combinational.
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) mem[sram_addr] <= sram_dq_out;
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts at posedge+1; drives one access through DONE and returns at posedge+1 after DONE.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input string name, output logic [31:0] rdata);
    rd_en = rd; wr_en = wr; address = a; write_data = d;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("%s ready c%0d", name, c), {31'd0, ready}, {31'd0, c == 5});
      if (wr && (c >= 1) && (c <= 4))
        check($sformatf("%s we_n c%0d", name, c), {31'd0, sram_we_n}, {31'd0, (c == 2) || (c == 4)});
      if (c == 5) rdata = read_data;
      @(posedge clk); #1;
      if (c == 0) begin
        address = ~a; write_data = ~d;
      end
    end
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_rdata;
    logic [ADDR_W-1:0] lo_idx;
  } vec_t;

  vec_t        vecs [8];
  logic [31:0] rdata;
  int          t0;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 16'h0000;
    vecs[0] = '{1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 32'h00000000, 18'd4};
    vecs[1] = '{1'b1, 1'b0, 32'd1032, 32'h0,        32'hDEADBEEF, 18'd4};
    vecs[2] = '{1'b0, 1'b1, 32'd1040, 32'h0BADF00D, 32'hDEADBEEF, 18'd8};
    vecs[3] = '{1'b1, 1'b0, 32'd1040, 32'h0,        32'h0BADF00D, 18'd8};
    vecs[4] = '{1'b0, 1'b1, 32'd0,    32'hA5A55A5A, 32'h0BADF00D, 18'h3FE00};
    vecs[5] = '{1'b1, 1'b0, 32'd0,    32'h0,        32'hA5A55A5A, 18'h3FE00};
    vecs[6] = '{1'b1, 1'b1, 32'd1056, 32'h13579BDF, 32'hA5A55A5A, 18'd16};
    vecs[7] = '{1'b1, 1'b0, 32'd1056, 32'h0,        32'h13579BDF, 18'd16};

    rst = 1'b0; rd_en = 0; wr_en = 0; address = 0; write_data = 0;
    rd_en3 = 0; wr_en3 = 0; address3 = 0; write_data3 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset ready", {31'd0, ready}, 32'd1);
    check("reset read_data", read_data, 32'd0);
    check("reset ctl_n", {29'd0, sram_we_n, sram_oe_n, sram_ce_n}, 32'd7);
    check("reset dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("reset addr", {14'd0, sram_addr}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("post-reset ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i), rdata);
      check($sformatf("vec%0d read_data", i), rdata, vecs[i].exp_rdata);
      if (vecs[i].wr) begin
        check($sformatf("vec%0d mem lo", i), {16'd0, mem[vecs[i].lo_idx]}, {16'd0, vecs[i].data[15:0]});
        check($sformatf("vec%0d mem hi", i), {16'd0, mem[vecs[i].lo_idx + 1'b1]}, {16'd0, vecs[i].data[31:16]});
      end
    end

    // Back-to-back: read is issued in the IDLE cycle right after the write's DONE.
    t0 = cyc;
    do_access(1'b0, 1'b1, 32'd1024, 32'h12345678, "b2b wr", rdata);
    do_access(1'b1, 1'b0, 32'd1024, 32'h0, "b2b rd", rdata);
    check("b2b read_data", rdata, 32'h12345678);
    check("b2b elapsed", cyc - t0, 32'd12);

    // Write request dropped at cycle 2 still completes both halfwords and pulses DONE.
    wr_en = 1'b1; address = 32'd1048; write_data = 32'hCAFEF00D;
    for (int c = 0; c <= 6; c++) begin
      @(negedge clk);
      check($sformatf("drop ready c%0d", c), {31'd0, ready}, {31'd0, c >= 5});
      @(posedge clk); #1;
      if (c == 1) wr_en = 1'b0;
    end
    check("drop mem lo", {16'd0, mem[12]}, 32'h0000F00D);
    check("drop mem hi", {16'd0, mem[13]}, 32'h0000CAFE);

    // Reset asserted during the HIGH phase of a read.
    rd_en = 1'b1; address = 32'd1032;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid oe_n in HIGH", {31'd0, sram_oe_n}, 32'd0);
    #1 rst = 1'b0; rd_en = 1'b0;
    #1;
    check("mid rst read_data", read_data, 32'd0);
    check("mid rst ctl_n", {29'd0, sram_we_n, sram_oe_n, sram_ce_n}, 32'd7);
    check("mid rst dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    check("mid rst addr", {14'd0, sram_addr}, 32'd0);
    check("mid rst ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    do_access(1'b1, 1'b0, 32'd1032, 32'h0, "post-rst rd", rdata);
    check("post-rst read_data", rdata, 32'hDEADBEEF);

    // Three wait states per phase: ready returns at cycle 7.
    wr_en3 = 1'b1; address3 = 32'd1024; write_data3 = 32'h55AA55AA;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      check($sformatf("ac3 ready c%0d", c), {31'd0, ready3}, {31'd0, c == 7});
      @(posedge clk); #1;
    end
    wr_en3 = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
